// File: rtl/reg_file_if.sv
// reg_file_if: read, write and context-stack signals between the control unit and the register file
interface reg_file_if #(
    parameter int WIDTH = 8,
    parameter int SIZE  = 11
);
    localparam int AW = $clog2(SIZE);
    logic [AW-1:0]    rf_addr_r1;
    logic [AW-1:0]    rf_addr_r2;
    logic [AW-1:0]    rf_addr_wr;
    logic [WIDTH-1:0] rf_data_out1;
    logic [WIDTH-1:0] rf_data_out2;
    logic [WIDTH-1:0] rf_data_in;
    logic             rf_data_we;
    logic             rf_stack_push;
    logic             rf_stack_pop;
    logic [5:0]       rf_stack_pointer;
    logic             rf_acc_zero;
    modport master (
        output rf_addr_r1, rf_addr_r2, rf_addr_wr, rf_data_in, rf_data_we,
               rf_stack_push, rf_stack_pop, rf_stack_pointer,
        input  rf_data_out1, rf_data_out2, rf_acc_zero
    );
    modport slave (
        input  rf_addr_r1, rf_addr_r2, rf_addr_wr, rf_data_in, rf_data_we,
               rf_stack_push, rf_stack_pop, rf_stack_pointer,
        output rf_data_out1, rf_data_out2, rf_acc_zero
    );
endinterface

// File: rtl/reg_file.sv
// reg_file: register file with constant R0/R1, accumulator zero flag and a context stack for R2..SIZE-1
module reg_file #(
    parameter int WIDTH       = 8,
    parameter int SIZE        = 11,
    parameter int STACK_DEPTH = 4
) (
    input logic       clk,
    input logic       rst,
    reg_file_if.slave bus
);
    localparam int AW = $clog2(SIZE);
    localparam int FW = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1;
    logic [WIDTH-1:0] regs [2:SIZE-1];
    logic [WIDTH-1:0] frames [STACK_DEPTH][2:SIZE-1];
    logic [5:0]       sp_m1;
    logic [FW-1:0]    f;
    logic             frame_ok, do_push, do_pop, wr_ok;
    // Frame is sp-1; sp==0 wraps sp_m1 to 63, so the depth compare alone rejects it too.
    assign sp_m1    = bus.rf_stack_pointer - 6'd1;
    assign f        = sp_m1[FW-1:0];
    assign frame_ok = bus.rf_stack_pointer != 6'd0 && int'(sp_m1) < STACK_DEPTH;
    assign do_push  = bus.rf_stack_push && !bus.rf_stack_pop && frame_ok;
    assign do_pop   = bus.rf_stack_pop && !bus.rf_stack_push && frame_ok;
    assign wr_ok    = bus.rf_data_we && int'(bus.rf_addr_wr) >= 2 && int'(bus.rf_addr_wr) < SIZE;
    function automatic logic [WIDTH-1:0] rd(input logic [AW-1:0] a);
        return int'(a) == 1 ? WIDTH'(1) : (int'(a) >= 2 && int'(a) < SIZE) ? regs[a] : '0;
    endfunction
    assign bus.rf_data_out1 = rd(bus.rf_addr_r1);
    assign bus.rf_data_out2 = rd(bus.rf_addr_r2);
    assign bus.rf_acc_zero  = regs[2] == '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            regs <= '{default: '0};
            for (int i = 0; i < STACK_DEPTH; i++) frames[i] <= '{default: '0};
        end else if (do_pop) begin
            regs <= frames[f];
        end else begin
            if (do_push) frames[f] <= regs;
            if (wr_ok) regs[bus.rf_addr_wr] <= bus.rf_data_in;
        end
    end
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed test-plan sequence plus randomized traffic checked against an array-based model
module tb_reg_file;
    localparam int WIDTH = 8;
    localparam int SIZE  = 11;
    localparam int DEPTH = 4;
    logic clk = 0;
    logic rst = 0;
    int checks = 0;
    int failures = 0;
    int m_regs [SIZE];
    int m_stack [DEPTH][SIZE];
    reg_file_if #(.WIDTH(WIDTH), .SIZE(SIZE)) bus ();
    reg_file #(.WIDTH(WIDTH), .SIZE(SIZE), .STACK_DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic int exp_read(input int a);
        return a == 1 ? 1 : (a >= 2 && a < SIZE) ? m_regs[a] : 0;
    endfunction
    task automatic check_outputs(input string tag);
        check({tag, " out1"}, int'(bus.rf_data_out1), exp_read(int'(bus.rf_addr_r1)));
        check({tag, " out2"}, int'(bus.rf_data_out2), exp_read(int'(bus.rf_addr_r2)));
        check({tag, " acc_zero"}, int'(bus.rf_acc_zero), int'(m_regs[2] == 0));
    endtask
    task automatic model_edge(input bit we, input int wa, input int din, input bit push, input bit pop,
                              input int sp, input bit r);
        bit ok;
        if (r) begin
            foreach (m_regs[i]) m_regs[i] = 0;
            foreach (m_stack[i, j]) m_stack[i][j] = 0;
            return;
        end
        ok = sp >= 1 && sp <= DEPTH;
        if (pop && !push && ok) begin
            for (int i = 2; i < SIZE; i++) m_regs[i] = m_stack[sp-1][i];
        end else begin
            if (push && !pop && ok)
                for (int i = 2; i < SIZE; i++) m_stack[sp-1][i] = m_regs[i];
            if (we && wa >= 2 && wa < SIZE) m_regs[wa] = din;
        end
    endtask
    task automatic cycle(input bit we, input int wa, input int din, input bit push, input bit pop,
                         input int sp, input bit r);
        bus.rf_data_we = we;
        bus.rf_addr_wr = 4'(wa);
        bus.rf_data_in = 8'(din);
        bus.rf_stack_push = push;
        bus.rf_stack_pop = pop;
        bus.rf_stack_pointer = 6'(sp);
        rst = r;
        #1;
        check_outputs("pre");
        @(posedge clk);
        model_edge(we, wa, din, push, pop, sp, r);
        #1;
        check_outputs("post");
        bus.rf_data_we = 0;
        bus.rf_stack_push = 0;
        bus.rf_stack_pop = 0;
        rst = 0;
    endtask
    task automatic peek(input string tag, input int a, input int exp);
        bus.rf_addr_r1 = 4'(a);
        #1;
        check(tag, int'(bus.rf_data_out1), exp);
    endtask
    task automatic wr(input int wa, input int din);
        cycle(1, wa, din, 0, 0, 0, 0);
    endtask
    initial begin
        bus.rf_addr_r1 = 0;
        bus.rf_addr_r2 = 0;
        bus.rf_addr_wr = 0;
        bus.rf_data_in = 0;
        bus.rf_data_we = 0;
        bus.rf_stack_push = 0;
        bus.rf_stack_pop = 0;
        bus.rf_stack_pointer = 0;
        @(negedge clk);
        cycle(0, 0, 0, 0, 0, 0, 1);
        peek("rst r0", 0, 0);
        peek("rst r1", 1, 1);
        peek("rst r5", 5, 0);
        peek("rst r15", 15, 0);
        check("rst acc_zero", int'(bus.rf_acc_zero), 1);
        bus.rf_addr_r1 = 3;
        wr(3, 'hB5);
        peek("r3 b5", 3, 'hB5);
        bus.rf_addr_r1 = 7;
        wr(7, 'h8A);
        peek("r7 8a", 7, 'h8A);
        wr(0, 'h8A);
        wr(1, 'h1F);
        wr(13, 'h44);
        peek("r0 const", 0, 0);
        peek("r1 const", 1, 1);
        peek("addr13", 13, 0);
        check("acc_zero before", int'(bus.rf_acc_zero), 1);
        wr(2, 'h1F);
        peek("r2 1f", 2, 'h1F);
        check("acc_zero after", int'(bus.rf_acc_zero), 0);
        bus.rf_addr_r1 = 7;
        bus.rf_addr_r2 = 4;
        wr(4, 'hAC);
        check("dual out1", int'(bus.rf_data_out1), 'h8A);
        check("dual out2", int'(bus.rf_data_out2), 'hAC);
        cycle(0, 0, 0, 1, 0, 1, 0);
        wr(3, 'hDC);
        wr(10, 'h6A);
        cycle(0, 0, 0, 1, 0, 2, 0);
        wr(3, 'h11);
        cycle(0, 0, 0, 0, 1, 2, 0);
        peek("pop2 r3", 3, 'hDC);
        peek("pop2 r10", 10, 'h6A);
        cycle(0, 0, 0, 0, 1, 1, 0);
        peek("pop1 r3", 3, 'hB5);
        peek("pop1 r10", 10, 0);
        peek("pop1 r4", 4, 'hAC);
        wr(3, 'h55);
        cycle(0, 0, 0, 0, 1, 0, 0);
        peek("pop sp0 r3", 3, 'h55);
        cycle(1, 5, 'h33, 1, 1, 1, 0);
        peek("push+pop write", 5, 'h33);
        cycle(1, 5, 'h44, 0, 1, 1, 0);
        peek("write+pop", 5, 0);
        wr(5, 'h66);
        cycle(1, 5, 'h77, 1, 0, 3, 0);
        peek("write+push reg", 5, 'h77);
        cycle(0, 0, 0, 0, 1, 3, 0);
        peek("write+push frame", 5, 'h66);
        cycle(1, 6, 'h12, 1, 0, 5, 0);
        cycle(0, 0, 0, 0, 1, 5, 0);
        peek("sp5 no-op", 6, 'h12);
        cycle(1, 3, 'hEE, 1, 0, 1, 1);
        for (int a = 0; a < 16; a++) peek("rst mid", a, a == 1 ? 1 : 0);
        check("rst mid acc_zero", int'(bus.rf_acc_zero), 1);
        wr(3, 'h9C);
        cycle(0, 0, 0, 0, 1, 1, 0);
        peek("pop after rst", 3, 0);
        for (int n = 0; n < 800; n++) begin
            bus.rf_addr_r1 = 4'($urandom_range(0, 15));
            bus.rf_addr_r2 = 4'($urandom_range(0, 15));
            cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                  $urandom_range(0, 3) == 0 ? 0 : int'($urandom_range(0, 255)),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  int'($urandom_range(0, 6)), $urandom_range(0, 99) == 0);
        end
        for (int a = 0; a < 16; a++) peek("final sweep", a, exp_read(a));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
